// File: rtl/sdram_line_bist.sv
// Line-oriented BIST engine for the sdram controller user port.
// On start it writes a pattern to NUM_LINES consecutive lines, reads every line
// back, and reports pass/fail, a saturating error count and the first bad address.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, mode           test launch pulse and pattern select (sampled on start)
//   busy, test_done, pass test status; pass is meaningful while test_done is high
//   timeout               sticky: a transaction never saw mem_done
//   err_count             mismatching lines (saturating)
//   first_err_addr        address of the first mismatching line
//   mem_*                 controller request/response port
module sdram_line_bist #(
   parameter int unsigned LINE_W      = 128,
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned ADDR_STRIDE = 8,
   parameter int unsigned NUM_LINES   = 256,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int unsigned TIMEOUT     = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   output logic              busy,
   output logic              test_done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic              mem_valid,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_init_done
);

   localparam int unsigned WORDS  = LINE_W / 16;
   localparam int unsigned LIDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
   localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(NUM_LINES - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(ADDR_STRIDE);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_INIT, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_CHK, S_FINISH
   } state_t;

   // One step of the Galois LFSR x^16+x^14+x^13+x^11+1, shifting right
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // LFSR state at the start of the following line
   function automatic logic [15:0] lfsr_next_line(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int unsigned k = 0; k < WORDS; k++) r = lfsr_step(r);
      return r;
   endfunction

   // Full line pattern for line idx; seed is the LFSR state at that line's word 0
   function automatic logic [LINE_W-1:0] gen_line(input logic [LIDX_W-1:0] idx,
                                                  input logic [15:0] seed,
                                                  input logic [1:0] md);
      logic [LINE_W-1:0] pat;
      logic [15:0]       s;
      logic [15:0]       cnt;
      logic [3:0]        rot;
      pat = '0;
      s   = seed;
      for (int unsigned k = 0; k < WORDS; k++) begin
         cnt = 16'(32'(idx) * WORDS + k);
         rot = 4'(idx) + 4'(k);
         case (md)
            2'd0: pat[16*k +: 16] = cnt;
            2'd1: pat[16*k +: 16] = ~cnt;
            2'd2: begin
               pat[16*k +: 16] = s;
               s = lfsr_step(s);
            end
            default: pat[16*k +: 16] = 16'h0001 << rot;
         endcase
      end
      return pat;
   endfunction

   state_t            state_q, state_d;
   logic [LIDX_W-1:0] line_q, line_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_d, ferr_d;
   logic [LINE_W-1:0] wdata_d;
   logic [15:0]       err_d;
   logic              busy_d, done_d, pass_d, tmo_d, wr_d, rd_d, valid_d, abort;

   logic              last_c, expired_c;
   logic [LIDX_W-1:0] nxt_line_c;
   logic [15:0]       nxt_lfsr_c;
   logic [LINE_W-1:0] cur_pat_c, nxt_pat_c;

   assign last_c     = (line_q == LAST_LINE);
   assign expired_c  = (cnt_q == CNT_LAST);
   assign nxt_line_c = line_q + LIDX_W'(1);
   assign nxt_lfsr_c = lfsr_next_line(lfsr_q);
   assign cur_pat_c  = gen_line(line_q, lfsr_q, mode_q);
   assign nxt_pat_c  = gen_line(nxt_line_c, nxt_lfsr_c, mode_q);

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         line_q         <= '0;
         lfsr_q         <= '0;
         mode_q         <= '0;
         cnt_q          <= '0;
         rdata_q        <= '0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
         busy           <= 1'b0;
         test_done      <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         mem_wr         <= 1'b0;
         mem_rd         <= 1'b0;
         mem_valid      <= 1'b0;
      end else begin
         state_q        <= state_d;
         line_q         <= line_d;
         lfsr_q         <= lfsr_d;
         mode_q         <= mode_d;
         cnt_q          <= cnt_d;
         rdata_q        <= rdata_d;
         mem_addr       <= addr_d;
         mem_wdata      <= wdata_d;
         err_count      <= err_d;
         first_err_addr <= ferr_d;
         busy           <= busy_d;
         test_done      <= done_d;
         pass           <= pass_d;
         timeout        <= tmo_d;
         mem_wr         <= wr_d;
         mem_rd         <= rd_d;
         mem_valid      <= valid_d;
      end
   end

   // Next-state and next-output logic; requests are asserted from the entering edge
   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      lfsr_d  = lfsr_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      err_d   = err_count;
      ferr_d  = first_err_addr;
      busy_d  = busy;
      done_d  = test_done;
      pass_d  = pass;
      tmo_d   = timeout;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      abort   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_WAIT_INIT;
               mode_d  = mode;
               line_d  = '0;
               lfsr_d  = SEED;
               addr_d  = BASE;
               cnt_d   = '0;
               err_d   = '0;
               ferr_d  = '0;
               tmo_d   = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_WAIT_INIT: begin
            if (mem_init_done) begin
               state_d = S_WR_REQ;
               wr_d    = 1'b1;
               cnt_d   = '0;
               wdata_d = cur_pat_c;
            end
         end
         S_WR_REQ: begin
            if (mem_done) begin
               state_d = S_WR_GAP;
            end else if (expired_c) begin
               abort = 1'b1;
            end else begin
               wr_d  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR_GAP: begin
            cnt_d = '0;
            if (last_c) begin
               state_d = S_RD_REQ;
               line_d  = '0;
               lfsr_d  = SEED;
               addr_d  = BASE;
               rd_d    = 1'b1;
            end else begin
               state_d = S_WR_REQ;
               line_d  = nxt_line_c;
               lfsr_d  = nxt_lfsr_c;
               addr_d  = mem_addr + STRIDE;
               wdata_d = nxt_pat_c;
               wr_d    = 1'b1;
            end
         end
         S_RD_REQ: begin
            if (mem_done) begin
               state_d = S_RD_CHK;
               rdata_d = mem_rdata;
            end else if (expired_c) begin
               abort = 1'b1;
            end else begin
               rd_d  = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RD_CHK: begin
            cnt_d = '0;
            if (rdata_q != cur_pat_c) begin
               if (err_count != 16'hFFFF) err_d = err_count + 16'd1;
               if (err_count == 16'd0) ferr_d = mem_addr;
            end
            if (last_c) begin
               state_d = S_FINISH;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (err_d == 16'd0) && !timeout;
            end else begin
               state_d = S_RD_REQ;
               line_d  = nxt_line_c;
               lfsr_d  = nxt_lfsr_c;
               addr_d  = mem_addr + STRIDE;
               rd_d    = 1'b1;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Controller never answered: give up on the whole test
      if (abort) begin
         state_d = S_FINISH;
         tmo_d   = 1'b1;
         done_d  = 1'b1;
         pass_d  = 1'b0;
         busy_d  = 1'b0;
      end

      valid_d = wr_d | rd_d;
   end

endmodule
